decode_stage: RTL and testbench

- RV32I decode stage. Sits directly downstream of fetch_stage and consumes its ins_o, pc_o and stall_o.
- Decodes the instruction, generates the immediate, and reads two operands from an internal register file. Results go into a registered pipeline slot for the execute stage.
- A one-entry skid buffer absorbs one instruction while execute is stalled. flush_i, driven from the same source as fetch's jmp_i, kills wrong-path work.

---
 rtl/core_pkg.sv | 49 ++++
 rtl/decode_stage_regfile.sv | 39 +++
 rtl/decode_stage.sv | 193 +++++++++++++++++++
 tb/tb_decode_stage.sv | 256 +++++++++++++++++++++++++
 4 files changed

// File: rtl/core_pkg.sv
// Shared RV32I definitions: major opcodes, decoded op classes and
// immediate formats used by the decode stage.
package core_pkg;

  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_FENCE  = 7'b0001111;
  localparam logic [6:0] OPC_SYSTEM = 7'b1110011;

  // OP_NONE is the reset/unknown-opcode class so an idle slot reads as 0
  typedef enum logic [3:0] {
    OP_NONE   = 4'd0,
    OP_LUI    = 4'd1,
    OP_AUIPC  = 4'd2,
    OP_JAL    = 4'd3,
    OP_JALR   = 4'd4,
    OP_BRANCH = 4'd5,
    OP_LOAD   = 4'd6,
    OP_STORE  = 4'd7,
    OP_OPIMM  = 4'd8,
    OP_OP     = 4'd9,
    OP_FENCE  = 4'd10,
    OP_SYSTEM = 4'd11
  } op_class_e;

  typedef enum logic [2:0] {
    IMM_I,
    IMM_S,
    IMM_B,
    IMM_U,
    IMM_J,
    IMM_NONE
  } imm_type_e;

  typedef struct packed {
    op_class_e op;
    imm_type_e imm_type;
    logic      writes_rd;
    logic      illegal;
  } dec_t;

endpackage

// File: rtl/decode_stage_regfile.sv
// 32x32 integer register file: two combinational read ports, one
// synchronous write port, x0 hardwired to zero, write-through bypass.
module regfile
  import core_pkg::*;
#(
  parameter int unsigned XLEN = 32
) (
  input  logic            clk,
  input  logic            we,
  input  logic [4:0]      wr_addr,
  input  logic [XLEN-1:0] wr_data,
  input  logic [4:0]      rs1_addr,
  output logic [XLEN-1:0] rs1_data,
  input  logic [4:0]      rs2_addr,
  output logic [XLEN-1:0] rs2_data
);

  logic [XLEN-1:0] mem [32];

  // Storage write; contents are intentionally not reset, x0 never written
  always_ff @(posedge clk) begin
    if (we && (wr_addr != 5'd0)) begin
      mem[wr_addr] <= wr_data;
    end
  end

  // Read ports with same-cycle writeback forwarding
  always_comb begin
    rs1_data = '0;
    rs2_data = '0;
    if (rs1_addr != 5'd0) begin
      rs1_data = (we && (wr_addr == rs1_addr)) ? wr_data : mem[rs1_addr];
    end
    if (rs2_addr != 5'd0) begin
      rs2_data = (we && (wr_addr == rs2_addr)) ? wr_data : mem[rs2_addr];
    end
  end

endmodule

// File: rtl/decode_stage.sv
// RV32I decode stage: instruction decode, immediate generation and operand
// read into a registered output slot, with a one-entry skid buffer that
// absorbs a single instruction while execute is stalled.
module decode_stage
  import core_pkg::*;
#(
  parameter int unsigned XLEN     = 32,
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [31:0]     ins_i,
  input  logic [XLEN-1:0] pc_i,
  input  logic            fetch_stall_i,
  input  logic            flush_i,
  input  logic            ex_stall_i,
  output logic            hold_o,
  input  logic            wb_we_i,
  input  logic [4:0]      wb_rd_i,
  input  logic [XLEN-1:0] wb_data_i,
  output logic            valid_o,
  output logic [XLEN-1:0] pc_o,
  output logic [3:0]      op_o,
  output logic [2:0]      funct3_o,
  output logic            funct7b5_o,
  output logic [4:0]      rs1_o,
  output logic [4:0]      rs2_o,
  output logic [4:0]      rd_o,
  output logic [XLEN-1:0] rs1_data_o,
  output logic [XLEN-1:0] rs2_data_o,
  output logic [XLEN-1:0] imm_o,
  output logic            rd_we_o,
  output logic            illegal_o
);

  function automatic dec_t decode(input logic [31:0] ins);
    dec_t       d;
    logic [6:0] f7;
    logic [2:0] f3;
    f7          = ins[31:25];
    f3          = ins[14:12];
    d.op        = OP_NONE;
    d.imm_type  = IMM_NONE;
    d.writes_rd = 1'b0;
    d.illegal   = 1'b0;
    case (ins[6:0])
      OPC_LUI:    begin d.op = OP_LUI;    d.imm_type = IMM_U; d.writes_rd = 1'b1; end
      OPC_AUIPC:  begin d.op = OP_AUIPC;  d.imm_type = IMM_U; d.writes_rd = 1'b1; end
      OPC_JAL:    begin d.op = OP_JAL;    d.imm_type = IMM_J; d.writes_rd = 1'b1; end
      OPC_JALR:   begin d.op = OP_JALR;   d.imm_type = IMM_I; d.writes_rd = 1'b1; end
      OPC_BRANCH: begin d.op = OP_BRANCH; d.imm_type = IMM_B; end
      OPC_LOAD:   begin d.op = OP_LOAD;   d.imm_type = IMM_I; d.writes_rd = 1'b1; end
      OPC_STORE:  begin d.op = OP_STORE;  d.imm_type = IMM_S; end
      OPC_OPIMM: begin
        d.op        = OP_OPIMM;
        d.imm_type  = IMM_I;
        d.writes_rd = 1'b1;
        // shift-immediate encodings carry a funct7 in the upper imm bits
        if ((f3 == 3'b001) && (f7 != 7'h00)) d.illegal = 1'b1;
        if ((f3 == 3'b101) && (f7 != 7'h00) && (f7 != 7'h20)) d.illegal = 1'b1;
      end
      OPC_OP: begin
        d.op        = OP_OP;
        d.writes_rd = 1'b1;
        if (f7 == 7'h20) begin
          d.illegal = !((f3 == 3'b000) || (f3 == 3'b101));
        end else if (f7 != 7'h00) begin
          d.illegal = 1'b1;
        end
      end
      OPC_FENCE:  d.op = OP_FENCE;
      OPC_SYSTEM: begin
        d.op        = OP_SYSTEM;
        d.imm_type  = IMM_I;
        d.writes_rd = (f3 != 3'b000);
      end
      default:    d.illegal = 1'b1;
    endcase
    if (ins[1:0] != 2'b11) d.illegal = 1'b1;
    if ((ins[11:7] == 5'd0) || d.illegal) d.writes_rd = 1'b0;
    return d;
  endfunction

  function automatic logic [31:0] gen_imm(input logic [31:0] ins, input imm_type_e t);
    logic [31:0] imm;
    case (t)
      IMM_I:   imm = {{20{ins[31]}}, ins[31:20]};
      IMM_S:   imm = {{20{ins[31]}}, ins[31:25], ins[11:7]};
      IMM_B:   imm = {{19{ins[31]}}, ins[31], ins[7], ins[30:25], ins[11:8], 1'b0};
      IMM_U:   imm = {ins[31:12], 12'b0};
      IMM_J:   imm = {{11{ins[31]}}, ins[31], ins[19:12], ins[20], ins[30:21], 1'b0};
      default: imm = '0;
    endcase
    return imm;
  endfunction

  logic            in_valid;
  logic            skid_full;
  logic [31:0]     skid_ins;
  logic [XLEN-1:0] skid_pc;

  logic            src_valid;
  logic [31:0]     src_ins;
  logic [XLEN-1:0] src_pc;
  dec_t            src_dec;
  logic [31:0]     src_imm;
  logic [XLEN-1:0] rs1_rdata;
  logic [XLEN-1:0] rs2_rdata;

  assign in_valid = !fetch_stall_i;

  // Select the instruction that would enter the output slot and decode it
  always_comb begin
    src_valid = skid_full || in_valid;
    src_ins   = skid_full ? skid_ins : ins_i;
    src_pc    = skid_full ? skid_pc  : pc_i;
    src_dec   = decode(src_ins);
    src_imm   = gen_imm(src_ins, src_dec.imm_type);
  end

  regfile #(
    .XLEN (XLEN)
  ) u_regfile (
    .clk      (clk),
    .we       (wb_we_i),
    .wr_addr  (wb_rd_i),
    .wr_data  (wb_data_i),
    .rs1_addr (src_ins[19:15]),
    .rs1_data (rs1_rdata),
    .rs2_addr (src_ins[24:20]),
    .rs2_data (rs2_rdata)
  );

  // Output slot and skid control: flush beats stall beats normal advance.
  // Operands are read as the instruction enters the slot, not when it is
  // parked in the skid, so writebacks during a stall are picked up.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      valid_o    <= 1'b0;
      hold_o     <= 1'b0;
      pc_o       <= RESET_PC;
      op_o       <= '0;
      funct3_o   <= '0;
      funct7b5_o <= 1'b0;
      rs1_o      <= '0;
      rs2_o      <= '0;
      rd_o       <= '0;
      rs1_data_o <= '0;
      rs2_data_o <= '0;
      imm_o      <= '0;
      rd_we_o    <= 1'b0;
      illegal_o  <= 1'b0;
      skid_full  <= 1'b0;
      skid_ins   <= '0;
      skid_pc    <= '0;
    end else begin
      if (!flush_i) begin
        assert (!(hold_o && in_valid));
      end
      if (flush_i) begin
        valid_o   <= 1'b0;
        skid_full <= 1'b0;
        hold_o    <= 1'b0;
      end else if (ex_stall_i && valid_o) begin
        if (in_valid && !skid_full) begin
          skid_ins  <= ins_i;
          skid_pc   <= pc_i;
          skid_full <= 1'b1;
          hold_o    <= 1'b1;
        end
      end else begin
        valid_o   <= src_valid;
        skid_full <= 1'b0;
        hold_o    <= 1'b0;
        if (src_valid) begin
          pc_o       <= src_pc;
          op_o       <= src_dec.op;
          funct3_o   <= src_ins[14:12];
          funct7b5_o <= src_ins[30];
          rs1_o      <= src_ins[19:15];
          rs2_o      <= src_ins[24:20];
          rd_o       <= src_ins[11:7];
          rs1_data_o <= rs1_rdata;
          rs2_data_o <= rs2_rdata;
          imm_o      <= src_imm;
          rd_we_o    <= src_dec.writes_rd;
          illegal_o  <= src_dec.illegal;
        end
      end
    end
  end

endmodule

// File: tb/tb_decode_stage.sv
// Directed bench for decode_stage: reset, decode/immediates, bypass,
// skid behaviour under execute stall, flush and illegal encodings.
module tb_decode_stage;
  import core_pkg::*;

  localparam logic [31:0] RST_PC = 32'h0000_0200;

  logic        clk;
  logic        rst;
  logic [31:0] ins_i;
  logic [31:0] pc_i;
  logic        fetch_stall_i;
  logic        flush_i;
  logic        ex_stall_i;
  logic        hold_o;
  logic        wb_we_i;
  logic [4:0]  wb_rd_i;
  logic [31:0] wb_data_i;
  logic        valid_o;
  logic [31:0] pc_o;
  logic [3:0]  op_o;
  logic [2:0]  funct3_o;
  logic        funct7b5_o;
  logic [4:0]  rs1_o;
  logic [4:0]  rs2_o;
  logic [4:0]  rd_o;
  logic [31:0] rs1_data_o;
  logic [31:0] rs2_data_o;
  logic [31:0] imm_o;
  logic        rd_we_o;
  logic        illegal_o;

  int checks;
  int failures;

  decode_stage #(
    .XLEN     (32),
    .RESET_PC (RST_PC)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .ins_i         (ins_i),
    .pc_i          (pc_i),
    .fetch_stall_i (fetch_stall_i),
    .flush_i       (flush_i),
    .ex_stall_i    (ex_stall_i),
    .hold_o        (hold_o),
    .wb_we_i       (wb_we_i),
    .wb_rd_i       (wb_rd_i),
    .wb_data_i     (wb_data_i),
    .valid_o       (valid_o),
    .pc_o          (pc_o),
    .op_o          (op_o),
    .funct3_o      (funct3_o),
    .funct7b5_o    (funct7b5_o),
    .rs1_o         (rs1_o),
    .rs2_o         (rs2_o),
    .rd_o          (rd_o),
    .rs1_data_o    (rs1_data_o),
    .rs2_data_o    (rs2_data_o),
    .imm_o         (imm_o),
    .rd_we_o       (rd_we_o),
    .illegal_o     (illegal_o)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    checks        = 0;
    failures      = 0;
    rst           = 1'b1;
    ins_i         = '0;
    pc_i          = '0;
    fetch_stall_i = 1'b1;
    flush_i       = 1'b0;
    ex_stall_i    = 1'b0;
    wb_we_i       = 1'b0;
    wb_rd_i       = '0;
    wb_data_i     = '0;

    #2 rst = 1'b0;
    tick();
    tick();
    chk("rst_valid", 32'(valid_o), 32'd0);
    chk("rst_hold",  32'(hold_o),  32'd0);
    chk("rst_pc",    pc_o,         RST_PC);
    chk("rst_op",    32'(op_o),    32'd0);
    chk("rst_imm",   imm_o,        32'd0);
    chk("rst_rdwe",  32'(rd_we_o), 32'd0);
    rst = 1'b1;

    for (int i = 0; i < 5; i++) begin
      tick();
      chk("idle_valid", 32'(valid_o), 32'd0);
      chk("idle_hold",  32'(hold_o),  32'd0);
      chk("idle_pc",    pc_o,         RST_PC);
    end

    // addi x1, x0, -1
    fetch_stall_i = 1'b0;
    ins_i = 32'hFFF00093; pc_i = 32'h10;
    tick();
    chk("addi_valid", 32'(valid_o),    32'd1);
    chk("addi_op",    32'(op_o),       32'(OP_OPIMM));
    chk("addi_rd",    32'(rd_o),       32'd1);
    chk("addi_imm",   imm_o,           32'hFFFFFFFF);
    chk("addi_rdwe",  32'(rd_we_o),    32'd1);
    chk("addi_rs1d",  rs1_data_o,      32'd0);
    chk("addi_pc",    pc_o,            32'h10);
    chk("addi_ill",   32'(illegal_o),  32'd0);

    // add x6, x5, x5 with x5 written back in the same cycle
    ins_i = 32'h00528333; pc_i = 32'h14;
    wb_we_i = 1'b1; wb_rd_i = 5'd5; wb_data_i = 32'hDEADBEEF;
    tick();
    wb_we_i = 1'b0;
    chk("add_op",   32'(op_o),    32'(OP_OP));
    chk("add_rs1d", rs1_data_o,   32'hDEADBEEF);
    chk("add_rs2d", rs2_data_o,   32'hDEADBEEF);
    chk("add_rd",   32'(rd_o),    32'd6);
    chk("add_imm",  imm_o,        32'd0);
    chk("add_rdwe", 32'(rd_we_o), 32'd1);

    // stall execute, present beq x0,x0,-4 -> parked in skid
    ex_stall_i = 1'b1;
    ins_i = 32'hFE000EE3; pc_i = 32'h18;
    tick();
    chk("stl_hold",  32'(hold_o),  32'd1);
    chk("stl_valid", 32'(valid_o), 32'd1);
    chk("stl_pc",    pc_o,         32'h14);
    chk("stl_op",    32'(op_o),    32'(OP_OP));
    fetch_stall_i = 1'b1;
    tick();
    chk("stl2_hold", 32'(hold_o), 32'd1);
    chk("stl2_pc",   pc_o,        32'h14);
    ex_stall_i = 1'b0;
    tick();
    chk("beq_op",   32'(op_o),    32'(OP_BRANCH));
    chk("beq_imm",  imm_o,        32'hFFFFFFFC);
    chk("beq_pc",   pc_o,         32'h18);
    chk("beq_hold", 32'(hold_o),  32'd0);
    chk("beq_rdwe", 32'(rd_we_o), 32'd0);

    // add x8, x5, x0 parked in skid while x5 is rewritten
    ex_stall_i = 1'b1; fetch_stall_i = 1'b0;
    ins_i = 32'h00028433; pc_i = 32'h1C;
    tick();
    chk("sk_hold", 32'(hold_o), 32'd1);
    chk("sk_pc",   pc_o,        32'h18);
    fetch_stall_i = 1'b1;
    wb_we_i = 1'b1; wb_rd_i = 5'd5; wb_data_i = 32'h12345678;
    tick();
    wb_we_i = 1'b0; ex_stall_i = 1'b0;
    tick();
    chk("sk_out_pc",   pc_o,         32'h1C);
    chk("sk_out_rs1d", rs1_data_o,   32'h12345678);
    chk("sk_out_rd",   32'(rd_o),    32'd8);
    chk("sk_out_hold", 32'(hold_o),  32'd0);

    // add x9, x0, x0 while writeback targets x0
    fetch_stall_i = 1'b0;
    ins_i = 32'h000004B3; pc_i = 32'h20;
    wb_we_i = 1'b1; wb_rd_i = 5'd0; wb_data_i = 32'hFFFFFFFF;
    tick();
    wb_we_i = 1'b0;
    chk("x0_rs1d", rs1_data_o,   32'd0);
    chk("x0_rs2d", rs2_data_o,   32'd0);
    chk("x0_rdwe", 32'(rd_we_o), 32'd1);

    // flush with skid full and a new instruction presented
    ex_stall_i = 1'b1;
    ins_i = 32'h00500113; pc_i = 32'h30;
    tick();
    chk("fl_pre_hold", 32'(hold_o), 32'd1);
    flush_i = 1'b1;
    ins_i = 32'h00700193; pc_i = 32'h34;
    tick();
    chk("fl_valid", 32'(valid_o), 32'd0);
    chk("fl_hold",  32'(hold_o),  32'd0);
    flush_i = 1'b0; ex_stall_i = 1'b0; fetch_stall_i = 1'b1;
    tick();
    chk("fl_after_valid", 32'(valid_o), 32'd0);
    chk("fl_after_hold",  32'(hold_o),  32'd0);
    tick();
    chk("fl_after2_valid", 32'(valid_o), 32'd0);

    // bubble in the slot does not block under ex_stall: lui x4, 0x12345
    ex_stall_i = 1'b1; fetch_stall_i = 1'b0;
    ins_i = 32'h12345237; pc_i = 32'h40;
    tick();
    chk("lui_valid", 32'(valid_o), 32'd1);
    chk("lui_hold",  32'(hold_o),  32'd0);
    chk("lui_op",    32'(op_o),    32'(OP_LUI));
    chk("lui_imm",   imm_o,        32'h12345000);
    chk("lui_rd",    32'(rd_o),    32'd4);

    // jal x1, +8
    ex_stall_i = 1'b0;
    ins_i = 32'h008000EF; pc_i = 32'h44;
    tick();
    chk("jal_op",   32'(op_o),    32'(OP_JAL));
    chk("jal_imm",  imm_o,        32'd8);
    chk("jal_pc",   pc_o,         32'h44);
    chk("jal_rdwe", 32'(rd_we_o), 32'd1);

    // sw x5, 12(x0)
    ins_i = 32'h00502623; pc_i = 32'h48;
    tick();
    chk("sw_op",   32'(op_o),      32'(OP_STORE));
    chk("sw_imm",  imm_o,          32'd12);
    chk("sw_rs2d", rs2_data_o,     32'h12345678);
    chk("sw_rdwe", 32'(rd_we_o),   32'd0);
    chk("sw_f3",   32'(funct3_o),  32'd2);

    // all-zero word: low bits not 2'b11
    ins_i = 32'h00000000; pc_i = 32'h4C;
    tick();
    chk("z_ill",   32'(illegal_o), 32'd1);
    chk("z_rdwe",  32'(rd_we_o),   32'd0);
    chk("z_valid", 32'(valid_o),   32'd1);

    // sll with funct7=0x20
    ins_i = 32'h40001033; pc_i = 32'h50;
    tick();
    chk("sll_ill",   32'(illegal_o),  32'd1);
    chk("sll_rdwe",  32'(rd_we_o),    32'd0);
    chk("sll_valid", 32'(valid_o),    32'd1);
    chk("sll_op",    32'(op_o),       32'(OP_OP));
    chk("sll_f7b5",  32'(funct7b5_o), 32'd1);

    // no input -> bubble
    fetch_stall_i = 1'b1;
    tick();
    chk("bub_valid", 32'(valid_o), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
